// File: rtl/clock_divider_switchable.sv
// Switchable divided-clock generator.
// Produces a registered divided clock plus a tick strobe in the source domain.
// Ratio changes and start/stop requests only take effect on period boundaries,
// so the output never shows a runt high or low phase.
module clock_divider_switchable #(
    parameter int DIVIDER_WIDTH   = 8,
    parameter int DEFAULT_DIVIDER = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic [DIVIDER_WIDTH-1:0] i_divider,
    input  logic                     i_divider_valid,
    output logic                     o_divider_ready,
    output logic                     o_clock_out,
    output logic                     o_tick,
    output logic                     o_switch_done,
    output logic                     o_running
);

    localparam int RESET_RATIO_INT = (DEFAULT_DIVIDER < 2) ? 2 : DEFAULT_DIVIDER;
    localparam logic [DIVIDER_WIDTH-1:0] RESET_RATIO = DIVIDER_WIDTH'(RESET_RATIO_INT);
    localparam logic [DIVIDER_WIDTH-1:0] MIN_RATIO   = DIVIDER_WIDTH'(2);
    localparam logic [DIVIDER_WIDTH-1:0] ONE         = DIVIDER_WIDTH'(1);
    localparam logic [DIVIDER_WIDTH-1:0] ZERO        = '0;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t                   r_state;
    logic [DIVIDER_WIDTH-1:0] r_counter;
    logic [DIVIDER_WIDTH-1:0] r_ratio;
    logic                     r_pending_valid;
    logic [DIVIDER_WIDTH-1:0] r_pending_ratio;
    logic                     r_clock_out;
    logic                     r_tick;
    logic                     r_switch_done;

    state_t                   w_next_state;
    logic [DIVIDER_WIDTH-1:0] w_next_counter;
    logic [DIVIDER_WIDTH-1:0] w_next_ratio;
    logic                     w_next_pending_valid;
    logic [DIVIDER_WIDTH-1:0] w_next_pending_ratio;
    logic                     w_next_clock_out;
    logic                     w_next_tick;
    logic                     w_next_switch_done;
    logic                     w_apply;
    logic                     w_accept;
    logic                     w_last_cycle;
    logic [DIVIDER_WIDTH:0]   w_ratio_plus_one;
    logic [DIVIDER_WIDTH-1:0] w_high_cycles;
    logic [DIVIDER_WIDTH-1:0] w_counter_inc;
    logic [DIVIDER_WIDTH-1:0] w_clamped_divider;

    // High phase is ceil(D/2); one extra bit keeps D+1 from overflowing at the maximum ratio.
    assign w_ratio_plus_one  = {1'b0, r_ratio} + (DIVIDER_WIDTH + 1)'(1);
    assign w_high_cycles     = w_ratio_plus_one[DIVIDER_WIDTH:1];
    assign w_counter_inc     = r_counter + ONE;
    assign w_last_cycle      = (r_counter == (r_ratio - ONE));
    assign w_clamped_divider = (i_divider < MIN_RATIO) ? MIN_RATIO : i_divider;
    assign w_accept          = i_divider_valid && !r_pending_valid;

    assign o_divider_ready = !r_pending_valid;
    assign o_clock_out     = r_clock_out;
    assign o_tick          = r_tick;
    assign o_switch_done   = r_switch_done;
    assign o_running       = (r_state == RUNNING);

    // Next-state logic: enable and pending ratios are only honoured at a period boundary.
    always_comb begin
        w_next_state       = r_state;
        w_next_counter     = r_counter;
        w_next_ratio       = r_ratio;
        w_next_clock_out   = 1'b0;
        w_next_tick        = 1'b0;
        w_next_switch_done = 1'b0;
        w_apply            = 1'b0;
        case (r_state)
            STOPPED: begin
                w_next_counter = ZERO;
                if (i_enable) begin
                    w_next_state     = RUNNING;
                    w_next_clock_out = 1'b1;
                    w_next_tick      = 1'b1;
                    w_apply          = r_pending_valid;
                end
            end
            RUNNING: begin
                if (w_last_cycle) begin
                    w_next_counter = ZERO;
                    if (i_enable) begin
                        w_next_clock_out = 1'b1;
                        w_next_tick      = 1'b1;
                        w_apply          = r_pending_valid;
                    end else begin
                        w_next_state = STOPPED;
                    end
                end else begin
                    w_next_counter   = w_counter_inc;
                    w_next_clock_out = (w_counter_inc < w_high_cycles);
                end
            end
            default: begin
                w_next_state   = STOPPED;
                w_next_counter = ZERO;
            end
        endcase
        if (w_apply) begin
            w_next_ratio       = r_pending_ratio;
            w_next_switch_done = 1'b1;
        end
    end

    // One-entry request holding slot: cleared when applied, filled on a handshake.
    always_comb begin
        w_next_pending_valid = r_pending_valid;
        w_next_pending_ratio = r_pending_ratio;
        if (w_apply) begin
            w_next_pending_valid = 1'b0;
        end
        if (w_accept) begin
            w_next_pending_valid = 1'b1;
            w_next_pending_ratio = w_clamped_divider;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state         <= STOPPED;
            r_counter       <= ZERO;
            r_ratio         <= RESET_RATIO;
            r_pending_valid <= 1'b0;
            r_pending_ratio <= RESET_RATIO;
            r_clock_out     <= 1'b0;
            r_tick          <= 1'b0;
            r_switch_done   <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_counter       <= w_next_counter;
            r_ratio         <= w_next_ratio;
            r_pending_valid <= w_next_pending_valid;
            r_pending_ratio <= w_next_pending_ratio;
            r_clock_out     <= w_next_clock_out;
            r_tick          <= w_next_tick;
            r_switch_done   <= w_next_switch_done;
        end
    end

endmodule

// File: doc/clock_divider_switchable.md
Name: clock_divider_switchable

Overview:
- Single-clock, parametrised divided-clock generator.
- Divide ratio changes glitch-free through a valid/ready request; a change takes effect only on a period boundary.
- Gated enable starts and stops the output only at period boundaries, so no runt high or low phase is ever emitted.
- Sits next to the glitch-free clock multiplexer as the source of low-rate functional clocks, with a companion tick strobe for logic that stays in the source domain.

Parameters:
- DIVIDER_WIDTH, 8, width of the divide ratio; maximum ratio 2^DIVIDER_WIDTH-1.
- DEFAULT_DIVIDER, 4, ratio active after reset; values below 2 are clamped to 2.

Ports:
- clock  input  1  source clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  run request; sampled only at period boundaries and in STOPPED.
- divider  input  DIVIDER_WIDTH  requested divide ratio.
- divider_valid  input  1  divider request valid.
- divider_ready  output  1  request can be accepted (no ratio pending).
- clock_out  output  1  divided clock, registered (no combinational path from clock).
- tick  output  1  one-cycle pulse coincident with each clock_out rising cycle.
- switch_done  output  1  one-cycle pulse in the first cycle of a period using a newly applied ratio.
- running  output  1  high in RUNNING state.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset values: clock_out=0, tick=0, switch_done=0, running=0, divider_ready=1, state=STOPPED, counter=0, active ratio=max(DEFAULT_DIVIDER,2), no pending request.
- Reset asserted mid-period: the next cycle returns to reset values. clock_out may drop early; this is accepted at reset only.
- Ratio D = active ratio; H = ceil(D/2) high cycles; L = floor(D/2) low cycles.
- Requested ratios below 2 are clamped to 2 on acceptance.
- Handshake: transfer when divider_valid && divider_ready.
  - Accepted value becomes pending; divider_ready drops the next cycle.
  - divider_ready rises again the cycle after the pending value is applied.
  - divider_valid while not ready is ignored (no queueing beyond one entry).
- State STOPPED:
  - clock_out=0, counter=0.
  - If enable=1 in cycle t, then at t+1: RUNNING, counter=0, clock_out=1, tick=1.
  - A pending ratio is applied at that same t+1 boundary, with switch_done=1.
- State RUNNING:
  - counter increments each cycle, 0..D-1; clock_out=1 while counter<H, else 0.
  - At counter=D-1 (last low cycle), enable=1: next cycle counter=0, clock_out=1, tick=1; a pending ratio, if any, becomes D there, with switch_done=1.
  - At counter=D-1, enable=0: next cycle STOPPED, clock_out stays 0. A pending ratio stays pending.
  - enable changes mid-period are ignored.
- Request accepted in the boundary cycle itself (counter=D-1): applied at the following boundary, not the immediate one.
- clock_out never has a high or low phase shorter than min(H,L) of the old or new ratio. Minimum phase is 1 cycle (D=2).
- Counter and comparisons are DIVIDER_WIDTH bits unsigned; no wrap occurs since counter<D≤2^W-1.

Test Plan:
- Reset, DEFAULT_DIVIDER=4, enable=1 -> first rising clock_out 2 cycles after reset release; pattern 1100 repeating; tick every 4 cycles; running=1.
- Odd ratio: request divider=5 while running at 4 -> current period completes; next period is 11100 with switch_done=1 on its first cycle; divider_ready 0 in between, 1 after.
- Clamp: request divider=0 and divider=1 -> output 10 repeating (D=2); all high and low phases exactly 1 cycle.
- Enable drop mid-high-phase at D=6 -> remaining high and low cycles complete (111000); then STOPPED with clock_out=0; re-enable -> rising edge 1 cycle after enable seen.
- Back-to-back requests 3 then 7 in consecutive cycles -> 7 is rejected (ready=0); only 3 is applied; a second 7 sent after ready rises is applied one boundary later.
- Random ratios 2..255 and random enable over 10000 cycles -> every high phase = ceil(D/2), every low phase ≥ floor(D/2) of the ratio in force; tick count equals rising-edge count; a reset pulse mid-run returns all outputs to reset values next cycle.
